// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // ceil(bin_w * log10(2)); log10(2) ~ 0.30103, and bin_w*log10(2) is never integral for bin_w > 0.
    function automatic int min_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Legal digits are 0..9, so the sum stays within 4 bits (max 12).
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Handshaked serial double-dabble converter: one input bit per cycle,
// optional sign-magnitude handling and sticky overflow detection.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_sign,
    output logic                  out_ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BIN_W-1:0]   bin_q;
    logic               sign_q;
    logic               ovf_q;
    logic               neg;
    logic [BIN_W-1:0]   mag;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (bcd_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
                .dout (bcd_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Two's-complement negate keeps BIN_W bits, so the most negative value maps to its exact magnitude.
    assign neg = (SIGNED != 0) && in_data[BIN_W-1];
    assign mag = neg ? (~in_data + {{(BIN_W-1){1'b0}}, 1'b1}) : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            bcd_q  <= '0;
            bin_q  <= '0;
            sign_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_q  <= mag;
                        sign_q <= neg;
                        bcd_q  <= '0;
                        ovf_q  <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                    ovf_q          <= ovf_q | bcd_adj[BCD_W-1];
                    cnt            <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign out_bcd   = out_valid ? bcd_q  : '0;
    assign out_sign  = out_valid ? sign_q : 1'b0;
    assign out_ovf   = out_valid ? ovf_q  : 1'b0;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three configurations (unsigned/3 digits, signed/3 digits, unsigned/2 digits).
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 8;
    localparam int N     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid_s  [N];
    logic [7:0]  in_data_s   [N];
    logic        in_ready_s  [N];
    logic        out_valid_s [N];
    logic        out_ready_s [N];
    logic [11:0] out_bcd_s   [N];
    logic        out_sign_s  [N];
    logic        out_ovf_s   [N];
    logic [7:0]  bcd_d2;

    int          or_mode [N];
    bit          busy    [N];
    int          acc     [N];
    logic [13:0] exp_q   [N][$];
    int          cyc       = 0;
    int          total     = 0;
    int          pass_cnt  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .in_data(in_data_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .out_bcd(out_bcd_s[0]), .out_sign(out_sign_s[0]), .out_ovf(out_ovf_s[0]));

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .in_data(in_data_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .out_bcd(out_bcd_s[1]), .out_sign(out_sign_s[1]), .out_ovf(out_ovf_s[1]));

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2), .SIGNED(0)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .in_data(in_data_s[2]), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
        .out_bcd(bcd_d2), .out_sign(out_sign_s[2]), .out_ovf(out_ovf_s[2]));

    assign out_bcd_s[2] = {4'h0, bcd_d2};

    // Reference: {sign, ovf, 3 BCD digits} from plain arithmetic.
    function automatic logic [13:0] model(input int k, input logic [7:0] d);
        int digits, mag, modv, r;
        logic sgn, ovf;
        logic [11:0] bcd;
        digits = (k == 2) ? 2 : 3;
        sgn    = (k == 1) && d[7];
        mag    = sgn ? 256 - int'(d) : int'(d);
        modv   = (digits == 2) ? 100 : 1000;
        ovf    = (mag >= modv);
        r      = mag % modv;
        bcd    = 12'((((r / 100) % 10) << 8) | (((r / 10) % 10) << 4) | (r % 10));
        return {sgn, ovf, bcd};
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            $display("FAIL %s inst=%0d cyc=%0d actual=%h expected=%h", nm, k, cyc, act, expv);
        end else begin
            pass_cnt++;
        end
    endtask

    // Per-cycle compare against the transaction-level model, then advance the model for the coming edge.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                chk("rst_in_ready", k, 32'(in_ready_s[k]), 32'd0);
                busy[k] = 1'b0;
                exp_q[k].delete();
            end else begin
                automatic bit ev = busy[k] && (cyc >= acc[k] + BIN_W);
                chk("in_ready", k, 32'(in_ready_s[k]), 32'(!busy[k]));
                chk("out_valid", k, 32'(out_valid_s[k]), 32'(ev));
                if (ev && exp_q[k].size() > 0) begin
                    chk("out_bcd",  k, 32'(out_bcd_s[k]),  32'(exp_q[k][0][11:0]));
                    chk("out_sign", k, 32'(out_sign_s[k]), 32'(exp_q[k][0][13]));
                    chk("out_ovf",  k, 32'(out_ovf_s[k]),  32'(exp_q[k][0][12]));
                end else begin
                    chk("idle_outs", k, {18'd0, out_sign_s[k], out_ovf_s[k], out_bcd_s[k]}, 32'd0);
                end
                if (ev && out_ready_s[k]) begin
                    void'(exp_q[k].pop_front());
                    busy[k] = 1'b0;
                end else if (!busy[k] && in_valid_s[k]) begin
                    exp_q[k].push_back(model(k, in_data_s[k]));
                    busy[k] = 1'b1;
                    acc[k]  = cyc + 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                case (or_mode[k])
                    1:       out_ready_s[k] = 1'($urandom_range(0, 1));
                    2:       out_ready_s[k] = 1'b0;
                    default: out_ready_s[k] = 1'b1;
                endcase
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d, output int acc_e);
        bit got = 1'b0;
        acc_e = -1;
        in_valid_s[k] = 1'b1;
        in_data_s[k]  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready_s[k]) begin
                acc_e = cyc + 1;
                got   = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid_s[k] = 1'b0;
        if (!got) chk("accept_timeout", k, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int k);
        bit done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy[k]) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!done) chk("idle_timeout", k, 32'd0, 32'd1);
    endtask

    initial begin
        int a0, a1, a2;
        bit seen;
        for (int k = 0; k < N; k++) begin
            in_valid_s[k] = 1'b0;
            in_data_s[k]  = 8'd0;
            out_ready_s[k] = 1'b1;
            or_mode[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("model_255",  0, 32'(model(0, 8'd255)), 32'h0255);
        chk("model_s80",  1, 32'(model(1, 8'h80)),  32'h2128);
        chk("model_sFF",  1, 32'(model(1, 8'hFF)),  32'h2001);
        chk("model_s7F",  1, 32'(model(1, 8'h7F)),  32'h0127);
        chk("model_d255", 2, 32'(model(2, 8'd255)), 32'h1055);
        chk("model_d99",  2, 32'(model(2, 8'd99)),  32'h0099);

        send(0, 8'd255, a0);
        wait_idle(0);

        send(0, 8'd0, a0);
        send(0, 8'd9, a1);
        send(0, 8'd10, a2);
        chk("interval_1", 0, 32'(a1 - a0), 32'(BIN_W + 2));
        chk("interval_2", 0, 32'(a2 - a1), 32'(BIN_W + 2));
        wait_idle(0);

        send(1, 8'h80, a0);
        send(1, 8'hFF, a0);
        send(1, 8'h7F, a0);
        wait_idle(1);

        send(2, 8'd255, a0);
        send(2, 8'd99, a0);
        wait_idle(2);

        // Backpressure: hold DONE, offer a word that must not be taken.
        or_mode[0] = 2;
        send(0, 8'd123, a0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid_s[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("stall_reached_done", 0, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 8'd55;
        repeat (5) @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        or_mode[0] = 0;
        wait_idle(0);

        // Abort mid-conversion, then a clean conversion afterwards.
        send(0, 8'd77, a0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 8'd200, a0);
        wait_idle(0);

        for (int k = 0; k < N; k++) begin
            or_mode[k] = 1;
            for (int i = 0; i < 30; i++) begin
                send(k, 8'($urandom_range(0, 255)), a0);
            end
            wait_idle(k);
            or_mode[k] = 0;
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
